// File: rtl/wptr_ctrl.sv
// Write-side pointer/status controller for the async FIFO: binary/Gray write
// pointers, read-pointer synchronizer, full/almost-full/level and overflow tracking.
module wptr_ctrl #(
   parameter int PTR_WIDTH     = 3,
   parameter int AFULL_LEVEL   = 6,
   parameter int OVF_CNT_WIDTH = 8
) (
   input  logic                     i_Wclk,
   input  logic                     i_Wrst,
   input  logic                     i_W_en,
   input  logic [PTR_WIDTH:0]       i_g_rptr,
   input  logic                     i_ovf_clr,
   output logic [PTR_WIDTH:0]       o_b_wptr,
   output logic [PTR_WIDTH:0]       o_g_wptr,
   output logic                     o_wr_accept,
   output logic                     o_full,
   output logic                     o_afull,
   output logic [PTR_WIDTH:0]       o_level,
   output logic                     o_overflow,
   output logic [OVF_CNT_WIDTH-1:0] o_ovf_cnt
);

   localparam int unsigned PW = PTR_WIDTH + 1;

   typedef logic [PTR_WIDTH:0]       ptr_t;
   typedef logic [OVF_CNT_WIDTH-1:0] cnt_t;

   ptr_t sync1_q, sync1_d;
   ptr_t sync2_q, sync2_d;
   ptr_t b_wptr_q, b_wptr_d;
   ptr_t g_wptr_q, g_wptr_d;
   logic full_q, full_d;
   logic afull_q, afull_d;
   ptr_t level_q, level_d;
   logic overflow_q, overflow_d;
   cnt_t ovf_cnt_q, ovf_cnt_d;

   logic wr_accept;
   logic ovf_event;
   ptr_t b_rptr_sync;
   ptr_t full_match;

   always_comb begin
      wr_accept = i_W_en & ~full_q;
      ovf_event = i_W_en & full_q;

      sync1_d = i_g_rptr;
      sync2_d = sync1_q;

      b_wptr_d = b_wptr_q + ptr_t'(wr_accept);
      g_wptr_d = (b_wptr_d >> 1) ^ b_wptr_d;

      // Full when the write pointer is one lap ahead: top two Gray bits inverted
      full_match = {~sync2_q[PTR_WIDTH:PTR_WIDTH-1], sync2_q[PTR_WIDTH-2:0]};
      full_d     = (g_wptr_d == full_match);

      b_rptr_sync = '0;
      for (int unsigned k = 0; k < PW; k++) begin
         b_rptr_sync[k] = ^(sync2_q >> k);
      end

      level_d = b_wptr_d - b_rptr_sync;
      afull_d = (level_d >= ptr_t'(AFULL_LEVEL));

      overflow_d = overflow_q;
      ovf_cnt_d  = ovf_cnt_q;
      // A dropped write in the clearing cycle restarts the count at one
      if (ovf_event) begin
         overflow_d = 1'b1;
         if (i_ovf_clr) begin
            ovf_cnt_d = cnt_t'(1);
         end else if (ovf_cnt_q != '1) begin
            ovf_cnt_d = ovf_cnt_q + cnt_t'(1);
         end
      end else if (i_ovf_clr) begin
         overflow_d = 1'b0;
         ovf_cnt_d  = '0;
      end
   end

   always_ff @(posedge i_Wclk or posedge i_Wrst) begin
      if (i_Wrst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         b_wptr_q   <= '0;
         g_wptr_q   <= '0;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         b_wptr_q   <= b_wptr_d;
         g_wptr_q   <= g_wptr_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   assign o_b_wptr    = b_wptr_q;
   assign o_g_wptr    = g_wptr_q;
   assign o_wr_accept = wr_accept;
   assign o_full      = full_q;
   assign o_afull     = afull_q;
   assign o_level     = level_q;
   assign o_overflow  = overflow_q;
   assign o_ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Scoreboard bench for wptr_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wptr_ctrl;

   logic       clk;
   logic       rst;
   logic       w_en;
   logic [3:0] g_rptr;
   logic       ovf_clr;
   logic [3:0] b_wptr;
   logic [3:0] g_wptr;
   logic       wr_accept;
   logic       full;
   logic       afull;
   logic [3:0] level;
   logic       overflow;
   logic [7:0] ovf_cnt;

   wptr_ctrl #(
      .PTR_WIDTH    (3),
      .AFULL_LEVEL  (6),
      .OVF_CNT_WIDTH(8)
   ) dut (
      .i_Wclk     (clk),
      .i_Wrst     (rst),
      .i_W_en     (w_en),
      .i_g_rptr   (g_rptr),
      .i_ovf_clr  (ovf_clr),
      .o_b_wptr   (b_wptr),
      .o_g_wptr   (g_wptr),
      .o_wr_accept(wr_accept),
      .o_full     (full),
      .o_afull    (afull),
      .o_level    (level),
      .o_overflow (overflow),
      .o_ovf_cnt  (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mask bits: 0 b, 1 g, 2 full, 3 afull, 4 level, 5 ovf, 6 cnt, 7 accept, 8 one-bit Gray step
   localparam logic [8:0] M_ALL  = 9'h0FF;
   localparam logic [8:0] M_WRAP = 9'h1FF;

   typedef struct {
      string      name;
      logic [8:0] m;
      logic [3:0] b;
      logic [3:0] g;
      logic       full;
      logic       afull;
      logic [3:0] lvl;
      logic       ovf;
      logic [7:0] cnt;
      logic       acc;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] prev_g = '0;

   function automatic exp_t mk(input string n, input logic [8:0] m,
                               input logic [3:0] b, input logic [3:0] g,
                               input logic fl, input logic af, input logic [3:0] lv,
                               input logic ov, input logic [7:0] cn, input logic ac);
      exp_t e;
      e.name = n; e.m = m; e.b = b; e.g = g; e.full = fl; e.afull = af;
      e.lvl = lv; e.ovf = ov; e.cnt = cn; e.acc = ac;
      return e;
   endfunction

   function automatic logic [3:0] gray(input int x);
      logic [3:0] v;
      v = 4'(x);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string n, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", n, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         if (cur.m[0]) chk({cur.name, ".b_wptr"},    int'(b_wptr),    int'(cur.b));
         if (cur.m[1]) chk({cur.name, ".g_wptr"},    int'(g_wptr),    int'(cur.g));
         if (cur.m[2]) chk({cur.name, ".full"},      int'(full),      int'(cur.full));
         if (cur.m[3]) chk({cur.name, ".afull"},     int'(afull),     int'(cur.afull));
         if (cur.m[4]) chk({cur.name, ".level"},     int'(level),     int'(cur.lvl));
         if (cur.m[5]) chk({cur.name, ".overflow"},  int'(overflow),  int'(cur.ovf));
         if (cur.m[6]) chk({cur.name, ".ovf_cnt"},   int'(ovf_cnt),   int'(cur.cnt));
         if (cur.m[7]) chk({cur.name, ".wr_accept"}, int'(wr_accept), int'(cur.acc));
         if (cur.m[8]) chk({cur.name, ".gray_step"}, $countones(g_wptr ^ prev_g), 1);
      end
      prev_g = g_wptr;
   end

   // Called just after a negedge; the expectation applies at the following negedge
   task automatic cyc(input logic w, input logic [3:0] gr, input logic clr, input exp_t e);
      w_en = w; g_rptr = gr; ovf_clr = clr;
      if (e.m != '0) sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   exp_t none;

   initial begin
      logic [3:0] b_tab [8];
      logic [3:0] g_tab [8];
      int lv;

      b_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
      g_tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      none  = mk("none", '0, '0, '0, 0, 0, '0, 0, '0, 0);

      rst = 1'b1; w_en = 1'b0; g_rptr = '0; ovf_clr = 1'b0;
      #1;
      sb.push_back(mk("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk); #1;
      rst = 1'b0;

      for (int k = 1; k <= 8; k++)
         cyc(1, 4'b0000, 0, mk($sformatf("fill%0d", k), M_ALL, b_tab[k-1], g_tab[k-1],
                               k == 8, k >= 6, 4'(k), 0, 0, k < 8));

      for (int k = 1; k <= 3; k++)
         cyc(1, 4'b0000, 0, mk($sformatf("ovf%0d", k), M_ALL, 8, 4'b1100, 1, 1, 8, 1, 8'(k), 0));
      cyc(0, 4'b0000, 1, mk("ovf_clr", M_ALL, 8, 4'b1100, 1, 1, 8, 0, 0, 0));

      cyc(0, 4'b0010, 0, mk("release1", M_ALL, 8, 4'b1100, 1, 1, 8, 0, 0, 0));
      cyc(0, 4'b0010, 0, mk("release2", M_ALL, 8, 4'b1100, 1, 1, 8, 0, 0, 0));
      cyc(0, 4'b0010, 0, mk("release3", M_ALL, 8, 4'b1100, 0, 0, 5, 0, 0, 0));

      // Read pointer trails the write pointer by two; sync latency shows level 6, 7 then 5
      for (int i = 1; i <= 40; i++) begin
         lv = (i == 1) ? 6 : (i == 2) ? 7 : 5;
         cyc(1, gray(5 + i), 0, mk($sformatf("wrap%0d", i), M_WRAP, 4'(8 + i), gray(8 + i),
                                   0, lv >= 6, 4'(lv), 0, 0, 1));
      end

      cyc(0, 4'b1001, 0, none);
      cyc(0, 4'b1001, 0, none);
      cyc(0, 4'b1001, 0, mk("settle", M_ALL, 0, 0, 0, 0, 2, 0, 0, 0));

      for (int k = 1; k <= 6; k++)
         cyc(1, 4'b1001, 0, mk($sformatf("refill%0d", k), M_ALL, 4'(k), gray(k),
                               k == 6, k >= 4, 4'(k + 2), 0, 0, k < 6));

      for (int k = 1; k <= 260; k++) begin
         if (k == 1 || k == 254 || k == 255 || k == 256 || k == 260)
            cyc(1, 4'b1001, 0, mk($sformatf("sat%0d", k), M_ALL, 6, 4'b0101, 1, 1, 8, 1,
                                  (k > 255) ? 8'd255 : 8'(k), 0));
         else
            cyc(1, 4'b1001, 0, none);
      end

      cyc(1, 4'b1001, 1, mk("collide", M_ALL, 6, 4'b0101, 1, 1, 8, 1, 1, 0));
      cyc(1, 4'b1001, 0, mk("after_collide", M_ALL, 6, 4'b0101, 1, 1, 8, 1, 2, 0));
      cyc(0, 4'b1001, 1, mk("clr_only", M_ALL, 6, 4'b0101, 1, 1, 8, 0, 0, 0));

      // Reset raised between edges must clear outputs before the next clock edge
      w_en = 1'b1; ovf_clr = 1'b0;
      sb.push_back(mk("async_rst", M_ALL, 0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      cyc(1, 4'b1001, 0, mk("post_rst", M_ALL, 1, 4'b0001, 0, 0, 1, 0, 0, 1));

      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wptr_ctrl.md
# wptr_ctrl

Write-side pointer and status controller for the asynchronous FIFO. It mirrors the read-pointer handler on the opposite clock domain. It keeps the binary and Gray write pointers and synchronizes the read-domain Gray pointer into the write clock. From these it derives full, almost-full and fill level, and records dropped (overflowed) writes. It sits between the write-side producer, the dual-port RAM write port and the read-side pointer handler.

## Interface
- PTR_WIDTH, 3: address width; FIFO depth = 2^PTR_WIDTH. Legal range ≥ 2.
- AFULL_LEVEL, 6: fill level at or above which o_afull asserts. Legal range 1..2^PTR_WIDTH.
- OVF_CNT_WIDTH, 8: width of the dropped-write counter.
- i_Wclk  in  1  write-domain clock; all state updates on its rising edge.
- i_Wrst  in  1  reset; asynchronous, active-high.
- i_W_en  in  1  write request from the producer.
- i_g_rptr  in  PTR_WIDTH+1  Gray read pointer from the read domain. Unsynchronized.
- i_ovf_clr  in  1  clears o_overflow and o_ovf_cnt.
- o_b_wptr  out  PTR_WIDTH+1  registered binary write pointer. Low PTR_WIDTH bits form the RAM write address.
- o_g_wptr  out  PTR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- o_wr_accept  out  1  combinational: i_W_en & !o_full. Drives the RAM write enable.
- o_full  out  1  registered full flag.
- o_afull  out  1  registered almost-full flag.
- o_level  out  PTR_WIDTH+1  registered write-domain fill level, 0..2^PTR_WIDTH.
- o_overflow  out  1  sticky; set when a write is attempted while full.
- o_ovf_cnt  out  OVF_CNT_WIDTH  saturating count of dropped writes.

## Operation
- Reset (i_Wrst high, asynchronous) clears all registers to 0, including both sync stages, pointers, o_full, o_afull, o_level, o_overflow and o_ovf_cnt. The read domain must be reset in the same window.
- Synchronizer: two flops. sync1 <= i_g_rptr; sync2 <= sync1. g_rptr_sync = sync2. No logic between the stages.
- Pointer path:
  - b_next = o_b_wptr + o_wr_accept, modulo 2^(PTR_WIDTH+1).
  - g_next = (b_next >> 1) ^ b_next.
  - Both pointers register the next values every edge.
- Full: full_next = (g_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}). o_full <= full_next.
- Level:
  - b_rptr_sync = Gray-to-binary of g_rptr_sync, where bit k = XOR of g bits PTR_WIDTH..k.
  - level_next = b_next − b_rptr_sync, modulo 2^(PTR_WIDTH+1). o_level <= level_next.
- Almost-full: o_afull <= (level_next >= AFULL_LEVEL).
- Overflow:
  - An overflow event is i_W_en & o_full.
  - On an event, o_overflow <= 1 and o_ovf_cnt increments. The counter saturates at all-ones.
  - i_ovf_clr alone clears both.
  - If i_ovf_clr and an event occur in the same cycle, the event wins over the clear: o_overflow <= 1 and o_ovf_cnt <= 1.
- Write pointer wrap-around is natural modulo 2^(PTR_WIDTH+1). The extra MSB distinguishes full from empty.
- Flags are pessimistic: o_full and o_level may overstate occupancy while read progress is in transit. They never understate it.

## Timing
- o_wr_accept is same-cycle combinational. The pointer advances on that edge.
- o_full asserts on the same edge that accepts the write filling the last entry. No write is accepted in the following cycle.
- Read progress: a change on i_g_rptr that is stable before edge N is visible on o_full, o_afull and o_level after edge N+2, i.e. three edges of latency.
- o_overflow and o_ovf_cnt update on the edge of the offending request.
- Reset asserted mid-operation clears outputs immediately and asynchronously. The first write after i_Wrst falls goes to address 0.

## Test plan
- Reset: hold i_W_en=1, pulse i_Wrst mid-cycle → all outputs 0 immediately; o_wr_accept=1 after release.
- Fill: i_g_rptr=0, eight consecutive writes →
  - o_b_wptr steps 1..8.
  - o_g_wptr ends at 4'b1100.
  - o_afull rises on the 6th edge, o_full on the 8th.
  - o_level=8.
- Overflow: with the FIFO full, three more requests →
  - o_wr_accept=0; o_b_wptr stays 8.
  - o_overflow=1, o_ovf_cnt=3.
  - One cycle with i_ovf_clr=1 → both 0.
- Release: from full, set i_g_rptr=4'b0010 (binary 3) → o_full falls and o_level=5 after the third edge; o_afull=0.
- Wrap: 40 writes with i_g_rptr tracking (write pointer − 2) in Gray → o_g_wptr changes exactly one bit per accepted write; o_full never asserts; o_level=2 at the end.
- Saturation and collision:
  - 260 requests while full → o_ovf_cnt=255.
  - i_ovf_clr together with a request → o_ovf_cnt=1, o_overflow=1.
